// File: rtl/alu_rs.sv
// alu_rs: reservation station holding ALU ops until operands arrive, dispatching one ready entry per cycle
module alu_rs #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_WIDTH = 4,
  parameter int OP_WIDTH  = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 issue_valid_in,
  input  logic [OP_WIDTH-1:0]  issue_op_in,
  input  logic [XLEN-1:0]      issue_vj_in,
  input  logic                 issue_qj_busy_in,
  input  logic [ROB_WIDTH-1:0] issue_qj_in,
  input  logic [XLEN-1:0]      issue_vk_in,
  input  logic                 issue_qk_busy_in,
  input  logic [ROB_WIDTH-1:0] issue_qk_in,
  input  logic [XLEN-1:0]      issue_pc_in,
  input  logic [XLEN-1:0]      issue_imm_in,
  input  logic [ROB_WIDTH-1:0] issue_dest_in,
  output logic                 full_out,
  input  logic                 cdb_valid_in,
  input  logic [ROB_WIDTH-1:0] cdb_tag_in,
  input  logic [XLEN-1:0]      cdb_value_in,
  output logic                 exec_valid_out,
  output logic [OP_WIDTH-1:0]  exec_op_out,
  output logic [XLEN-1:0]      exec_rs_out,
  output logic [XLEN-1:0]      exec_rt_out,
  output logic [XLEN-1:0]      exec_pc_out,
  output logic [XLEN-1:0]      exec_imm_out,
  output logic [ROB_WIDTH-1:0] exec_dest_out
);
  localparam int IW = $clog2(RS_SIZE);
  typedef struct packed {
    logic                 busy;
    logic [OP_WIDTH-1:0]  op;
    logic [XLEN-1:0]      vj;
    logic                 qj_busy;
    logic [ROB_WIDTH-1:0] qj;
    logic [XLEN-1:0]      vk;
    logic                 qk_busy;
    logic [ROB_WIDTH-1:0] qk;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [ROB_WIDTH-1:0] dest;
  } entry_t;
  entry_t               ent_q [RS_SIZE];
  entry_t               ent_d [RS_SIZE];
  logic [RS_SIZE-1:0]   busy_vec;
  logic [IW-1:0]        sel_idx;
  logic [IW-1:0]        free_idx;
  logic                 sel_vld;
  logic                 exec_valid_q, exec_valid_d;
  logic [OP_WIDTH-1:0]  exec_op_q, exec_op_d;
  logic [XLEN-1:0]      exec_rs_q, exec_rs_d;
  logic [XLEN-1:0]      exec_rt_q, exec_rt_d;
  logic [XLEN-1:0]      exec_pc_q, exec_pc_d;
  logic [XLEN-1:0]      exec_imm_q, exec_imm_d;
  logic [ROB_WIDTH-1:0] exec_dest_q, exec_dest_d;
  logic                 bypass_j, bypass_k;
  // lowest-index ready entry for dispatch and lowest-index free slot for issue
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    free_idx = '0;
    busy_vec = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      busy_vec[i] = ent_q[i].busy;
      if (ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
      if (!ent_q[i].busy) free_idx = IW'(i);
    end
  end
  assign full_out = &busy_vec;
  assign bypass_j = cdb_valid_in && (cdb_tag_in == issue_qj_in);
  assign bypass_k = cdb_valid_in && (cdb_tag_in == issue_qk_in);
  // entry updates: free the dispatched slot, CDB wakeup, then fill a free slot with the issued op
  always_comb begin
    ent_d = ent_q;
    if (sel_vld) ent_d[sel_idx].busy = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (cdb_valid_in && ent_q[i].busy && ent_q[i].qj_busy && ent_q[i].qj == cdb_tag_in) begin
        ent_d[i].vj      = cdb_value_in;
        ent_d[i].qj_busy = 1'b0;
      end
      if (cdb_valid_in && ent_q[i].busy && ent_q[i].qk_busy && ent_q[i].qk == cdb_tag_in) begin
        ent_d[i].vk      = cdb_value_in;
        ent_d[i].qk_busy = 1'b0;
      end
    end
    if (issue_valid_in && !full_out) begin
      ent_d[free_idx].busy    = 1'b1;
      ent_d[free_idx].op      = issue_op_in;
      ent_d[free_idx].qj      = issue_qj_in;
      ent_d[free_idx].qk      = issue_qk_in;
      ent_d[free_idx].qj_busy = issue_qj_busy_in && !bypass_j;
      ent_d[free_idx].qk_busy = issue_qk_busy_in && !bypass_k;
      ent_d[free_idx].vj      = issue_qj_busy_in ? cdb_value_in : issue_vj_in;
      ent_d[free_idx].vk      = issue_qk_busy_in ? cdb_value_in : issue_vk_in;
      ent_d[free_idx].pc      = issue_pc_in;
      ent_d[free_idx].imm     = issue_imm_in;
      ent_d[free_idx].dest    = issue_dest_in;
    end
  end
  // dispatch register: load the selected entry, otherwise hold payload and drop valid
  always_comb begin
    exec_valid_d = sel_vld;
    exec_op_d    = sel_vld ? ent_q[sel_idx].op   : exec_op_q;
    exec_rs_d    = sel_vld ? ent_q[sel_idx].vj   : exec_rs_q;
    exec_rt_d    = sel_vld ? ent_q[sel_idx].vk   : exec_rt_q;
    exec_pc_d    = sel_vld ? ent_q[sel_idx].pc   : exec_pc_q;
    exec_imm_d   = sel_vld ? ent_q[sel_idx].imm  : exec_imm_q;
    exec_dest_d  = sel_vld ? ent_q[sel_idx].dest : exec_dest_q;
  end
  // state register: reset beats flush beats stall; payload fields need no reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
      exec_valid_q <= 1'b0;
      exec_op_q    <= '0;
      exec_rs_q    <= '0;
      exec_rt_q    <= '0;
      exec_pc_q    <= '0;
      exec_imm_q   <= '0;
      exec_dest_q  <= '0;
    end else if (flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
      exec_valid_q <= 1'b0;
    end else if (rdy_in) begin
      ent_q        <= ent_d;
      exec_valid_q <= exec_valid_d;
      exec_op_q    <= exec_op_d;
      exec_rs_q    <= exec_rs_d;
      exec_rt_q    <= exec_rt_d;
      exec_pc_q    <= exec_pc_d;
      exec_imm_q   <= exec_imm_d;
      exec_dest_q  <= exec_dest_d;
    end
  end
  assign exec_valid_out = exec_valid_q;
  assign exec_op_out    = exec_op_q;
  assign exec_rs_out    = exec_rs_q;
  assign exec_rt_out    = exec_rt_q;
  assign exec_pc_out    = exec_pc_q;
  assign exec_imm_out   = exec_imm_q;
  assign exec_dest_out  = exec_dest_q;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus randomized run against a slot-level reference model
module tb_alu_rs;
  localparam int N = 8, RW = 4, OW = 6, XL = 32;
  localparam logic [OW-1:0] OP_ADDI = 6'd10, OP_ADD = 6'd1;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in, issue_valid_in, issue_qj_busy_in, issue_qk_busy_in, cdb_valid_in;
  logic [OW-1:0] issue_op_in;
  logic [XL-1:0] issue_vj_in, issue_vk_in, issue_pc_in, issue_imm_in, cdb_value_in;
  logic [RW-1:0] issue_qj_in, issue_qk_in, issue_dest_in, cdb_tag_in;
  logic full_out, exec_valid_out;
  logic [OW-1:0] exec_op_out;
  logic [XL-1:0] exec_rs_out, exec_rt_out, exec_pc_out, exec_imm_out;
  logic [RW-1:0] exec_dest_out;
  int checks = 0, failures = 0;

  alu_rs #(.RS_SIZE(N), .ROB_WIDTH(RW), .OP_WIDTH(OW), .XLEN(XL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_op_in(issue_op_in), .issue_vj_in(issue_vj_in),
    .issue_qj_busy_in(issue_qj_busy_in), .issue_qj_in(issue_qj_in), .issue_vk_in(issue_vk_in),
    .issue_qk_busy_in(issue_qk_busy_in), .issue_qk_in(issue_qk_in), .issue_pc_in(issue_pc_in),
    .issue_imm_in(issue_imm_in), .issue_dest_in(issue_dest_in), .full_out(full_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .exec_valid_out(exec_valid_out), .exec_op_out(exec_op_out), .exec_rs_out(exec_rs_out),
    .exec_rt_out(exec_rt_out), .exec_pc_out(exec_pc_out), .exec_imm_out(exec_imm_out),
    .exec_dest_out(exec_dest_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0; issue_valid_in = 1'b0; cdb_valid_in = 1'b0;
    issue_op_in = '0; issue_vj_in = '0; issue_qj_busy_in = 1'b0; issue_qj_in = '0;
    issue_vk_in = '0; issue_qk_busy_in = 1'b0; issue_qk_in = '0; issue_pc_in = '0;
    issue_imm_in = '0; issue_dest_in = '0; cdb_tag_in = '0; cdb_value_in = '0;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic jb, input logic [RW-1:0] qj, input logic [XL-1:0] vj,
                       input logic kb, input logic [RW-1:0] qk, input logic [XL-1:0] vk,
                       input logic [XL-1:0] imm, input logic [RW-1:0] dest);
    issue_valid_in = 1'b1; issue_op_in = op; issue_qj_busy_in = jb; issue_qj_in = qj; issue_vj_in = vj;
    issue_qk_busy_in = kb; issue_qk_in = qk; issue_vk_in = vk; issue_imm_in = imm; issue_dest_in = dest;
    issue_pc_in = 32'h1000 + 32'(dest);
  endtask

  task automatic test_reset();
    idle(); rst_in = 1'b1; tick(); tick(); rst_in = 1'b0;
    checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", exec_valid_out); end
    checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", full_out); end
    checks++; if ({exec_op_out, exec_rs_out, exec_rt_out, exec_pc_out, exec_imm_out, exec_dest_out} !== '0) begin
      failures++; $display("FAIL reset_exec_fields got op=%0h rs=%0h dest=%0h exp=0", exec_op_out, exec_rs_out, exec_dest_out); end
  endtask

  task automatic test_ready_issue();
    issue(OP_ADDI, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0, 32'd7, 4'd3); tick(); idle();
    checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL addi_early got=%0h exp=0", exec_valid_out); end
    tick();
    checks++; if (exec_valid_out !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", exec_valid_out); end
    checks++; if (exec_op_out !== OP_ADDI || exec_rs_out !== 32'd5 || exec_imm_out !== 32'd7 || exec_dest_out !== 4'd3 || exec_pc_out !== 32'h1003) begin
      failures++; $display("FAIL addi_fields got op=%0h rs=%0h imm=%0h dest=%0h pc=%0h exp op=%0h rs=5 imm=7 dest=3 pc=1003", exec_op_out, exec_rs_out, exec_imm_out, exec_dest_out, exec_pc_out, OP_ADDI); end
    tick();
    checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL addi_pulse got=%0h exp=0", exec_valid_out); end
  endtask

  task automatic test_cdb_wakeup();
    issue(OP_ADD, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd10, 32'd0, 4'd4); tick(); idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL wake_hold%0d got=%0h exp=0", c, exec_valid_out); end
    end
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd2; cdb_value_in = 32'd20; tick(); idle();
    checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL wake_same_edge got=%0h exp=0", exec_valid_out); end
    tick();
    checks++; if (exec_valid_out !== 1'b1 || exec_rs_out !== 32'd20 || exec_rt_out !== 32'd10 || exec_dest_out !== 4'd4) begin
      failures++; $display("FAIL wake_dispatch got v=%0h rs=%0d rt=%0d dest=%0d exp v=1 rs=20 rt=10 dest=4", exec_valid_out, exec_rs_out, exec_rt_out, exec_dest_out); end
    tick();
  endtask

  task automatic test_bypass();
    issue(OP_ADD, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd3, 32'd0, 4'd6);
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd6; cdb_value_in = 32'hDEAD; tick(); idle();
    checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL bypass_early got=%0h exp=0", exec_valid_out); end
    tick();
    checks++; if (exec_valid_out !== 1'b1 || exec_rs_out !== 32'hDEAD || exec_rt_out !== 32'd3) begin
      failures++; $display("FAIL bypass_dispatch got v=%0h rs=%0h rt=%0h exp v=1 rs=dead rt=3", exec_valid_out, exec_rs_out, exec_rt_out); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < N; i++) begin
      issue(OP_ADD, 1'b1, (i == 5) ? 4'd9 : 4'(i + 8), 32'd0, 1'b0, 4'd0, 32'(100 + i), 32'd0, 4'(i)); tick();
    end
    idle();
    checks++; if (full_out !== 1'b1) begin failures++; $display("FAIL full_set got=%0h exp=1", full_out); end
    issue(OP_ADDI, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd9); tick(); idle(); tick();
    checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL full_ninth_ignored got=%0h exp=0", exec_valid_out); end
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd9; cdb_value_in = 32'd77; tick(); idle();
    checks++; if (full_out !== 1'b1 || exec_valid_out !== 1'b0) begin failures++; $display("FAIL full_wake_edge got full=%0h v=%0h exp full=1 v=0", full_out, exec_valid_out); end
    tick();
    checks++; if (exec_valid_out !== 1'b1 || exec_dest_out !== 4'd1 || exec_rs_out !== 32'd77 || exec_rt_out !== 32'd101) begin
      failures++; $display("FAIL full_first got v=%0h dest=%0d rs=%0d rt=%0d exp v=1 dest=1 rs=77 rt=101", exec_valid_out, exec_dest_out, exec_rs_out, exec_rt_out); end
    checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL full_fall got=%0h exp=0", full_out); end
    tick();
    checks++; if (exec_valid_out !== 1'b1 || exec_dest_out !== 4'd5 || exec_rt_out !== 32'd105) begin
      failures++; $display("FAIL full_second got v=%0h dest=%0d rt=%0d exp v=1 dest=5 rt=105", exec_valid_out, exec_dest_out, exec_rt_out); end
    tick();
    checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL full_after got=%0h exp=0", exec_valid_out); end
    flush_in = 1'b1; tick(); idle();
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 4; i++) begin
      issue(OP_ADD, 1'b1, 4'(i), 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'(i)); tick();
    end
    idle();
    checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL flush_pre_full got=%0h exp=0", full_out); end
    flush_in = 1'b1; issue(OP_ADDI, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd12);
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd1; cdb_value_in = 32'd9; tick(); idle();
    checks++; if (exec_valid_out !== 1'b0 || full_out !== 1'b0) begin failures++; $display("FAIL flush_clear got v=%0h full=%0h exp 0 0", exec_valid_out, full_out); end
    for (int t = 1; t <= 4; t++) begin
      cdb_valid_in = 1'b1; cdb_tag_in = 4'(t); cdb_value_in = 32'(t); tick();
      checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL flush_stale_tag%0d got=%0h exp=0", t, exec_valid_out); end
    end
    idle(); tick();
    checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL flush_stale_last got=%0h exp=0", exec_valid_out); end
  endtask

  task automatic test_rdy();
    issue(OP_ADD, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd1, 32'd0, 4'd2); tick();
    issue(OP_ADDI, 1'b0, 4'd0, 32'd31, 1'b0, 4'd0, 32'd0, 32'd0, 4'd7); tick();
    issue(OP_ADDI, 1'b0, 4'd0, 32'd44, 1'b0, 4'd0, 32'd0, 32'd0, 4'd8); tick(); idle();
    checks++; if (exec_valid_out !== 1'b1 || exec_dest_out !== 4'd7) begin failures++; $display("FAIL rdy_pre got v=%0h dest=%0d exp v=1 dest=7", exec_valid_out, exec_dest_out); end
    rdy_in = 1'b0; cdb_valid_in = 1'b1; cdb_tag_in = 4'd3; cdb_value_in = 32'd55;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (exec_valid_out !== 1'b1 || exec_dest_out !== 4'd7 || exec_rs_out !== 32'd31) begin
        failures++; $display("FAIL rdy_hold%0d got v=%0h dest=%0d rs=%0d exp v=1 dest=7 rs=31", c, exec_valid_out, exec_dest_out, exec_rs_out); end
    end
    idle(); tick();
    checks++; if (exec_valid_out !== 1'b1 || exec_dest_out !== 4'd8 || exec_rs_out !== 32'd44) begin
      failures++; $display("FAIL rdy_resume got v=%0h dest=%0d rs=%0d exp v=1 dest=8 rs=44", exec_valid_out, exec_dest_out, exec_rs_out); end
    tick();
    checks++; if (exec_valid_out !== 1'b0) begin failures++; $display("FAIL rdy_no_wake got=%0h exp=0", exec_valid_out); end
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd3; cdb_value_in = 32'd55; tick(); idle(); tick();
    checks++; if (exec_valid_out !== 1'b1 || exec_dest_out !== 4'd2 || exec_rs_out !== 32'd55 || exec_rt_out !== 32'd1) begin
      failures++; $display("FAIL rdy_late_wake got v=%0h dest=%0d rs=%0d rt=%0d exp v=1 dest=2 rs=55 rt=1", exec_valid_out, exec_dest_out, exec_rs_out, exec_rt_out); end
    tick();
  endtask

  typedef struct {
    bit busy, jb, kb;
    logic [OW-1:0] op;
    logic [XL-1:0] vj, vk, pc, imm;
    logic [RW-1:0] qj, qk, dest;
  } m_ent_t;

  task automatic test_random();
    m_ent_t m [N];
    bit e_v, was_full;
    logic [OW-1:0] e_op;
    logic [XL-1:0] e_rs, e_rt, e_pc, e_imm;
    logic [RW-1:0] e_dest;
    int s, f;
    idle(); rst_in = 1'b1; tick(); rst_in = 1'b0;
    for (int i = 0; i < N; i++) m[i].busy = 0;
    e_v = 0; e_op = '0; e_rs = '0; e_rt = '0; e_pc = '0; e_imm = '0; e_dest = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      flush_in = ($urandom_range(0, 59) == 0);
      cdb_valid_in = $urandom_range(0, 1); cdb_tag_in = 4'($urandom_range(0, 7)); cdb_value_in = $urandom;
      issue_valid_in = ($urandom_range(0, 2) != 0); issue_op_in = 6'($urandom);
      issue_qj_busy_in = $urandom_range(0, 1); issue_qj_in = 4'($urandom_range(0, 7)); issue_vj_in = $urandom;
      issue_qk_busy_in = $urandom_range(0, 1); issue_qk_in = 4'($urandom_range(0, 7)); issue_vk_in = $urandom;
      issue_pc_in = $urandom; issue_imm_in = $urandom; issue_dest_in = 4'($urandom);
      if (flush_in) begin
        for (int i = 0; i < N; i++) m[i].busy = 0;
        e_v = 0;
      end else if (rdy_in) begin
        s = -1; f = -1; was_full = 1;
        for (int i = 0; i < N; i++) begin
          if (s < 0 && m[i].busy && !m[i].jb && !m[i].kb) s = i;
          if (f < 0 && !m[i].busy) f = i;
          if (!m[i].busy) was_full = 0;
        end
        e_v = (s >= 0);
        if (s >= 0) begin
          e_op = m[s].op; e_rs = m[s].vj; e_rt = m[s].vk; e_pc = m[s].pc; e_imm = m[s].imm; e_dest = m[s].dest;
          m[s].busy = 0;
        end
        for (int i = 0; i < N; i++) if (m[i].busy && cdb_valid_in) begin
          if (m[i].jb && m[i].qj == cdb_tag_in) begin m[i].vj = cdb_value_in; m[i].jb = 0; end
          if (m[i].kb && m[i].qk == cdb_tag_in) begin m[i].vk = cdb_value_in; m[i].kb = 0; end
        end
        if (issue_valid_in && !was_full) begin
          m[f].busy = 1; m[f].op = issue_op_in; m[f].pc = issue_pc_in; m[f].imm = issue_imm_in; m[f].dest = issue_dest_in;
          m[f].qj = issue_qj_in; m[f].qk = issue_qk_in;
          if (!issue_qj_busy_in) begin m[f].jb = 0; m[f].vj = issue_vj_in; end
          else if (cdb_valid_in && cdb_tag_in == issue_qj_in) begin m[f].jb = 0; m[f].vj = cdb_value_in; end
          else m[f].jb = 1;
          if (!issue_qk_busy_in) begin m[f].kb = 0; m[f].vk = issue_vk_in; end
          else if (cdb_valid_in && cdb_tag_in == issue_qk_in) begin m[f].kb = 0; m[f].vk = cdb_value_in; end
          else m[f].kb = 1;
        end
      end
      tick();
      was_full = 1;
      for (int i = 0; i < N; i++) if (!m[i].busy) was_full = 0;
      checks++; if (full_out !== was_full) begin failures++; $display("FAIL rand_full cyc=%0d got=%0h exp=%0h", cyc, full_out, was_full); end
      checks++; if (exec_valid_out !== e_v) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0h exp=%0h", cyc, exec_valid_out, e_v); end
      checks++; if ({exec_op_out, exec_rs_out, exec_rt_out, exec_pc_out, exec_imm_out, exec_dest_out} !== {e_op, e_rs, e_rt, e_pc, e_imm, e_dest}) begin
        failures++; $display("FAIL rand_fields cyc=%0d got op=%0h rs=%0h rt=%0h pc=%0h imm=%0h dest=%0h exp op=%0h rs=%0h rt=%0h pc=%0h imm=%0h dest=%0h",
          cyc, exec_op_out, exec_rs_out, exec_rt_out, exec_pc_out, exec_imm_out, exec_dest_out, e_op, e_rs, e_rt, e_pc, e_imm, e_dest); end
    end
    idle();
  endtask

  initial begin
    rst_in = 1'b1;
    idle();
    test_reset();
    test_ready_issue();
    test_cdb_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_rdy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the integer ALU path of the out-of-order core.
- Sits between the issue stage and the combinational ALU. Holds decoded ALU/branch/jump instructions until both source operands are available.
- Snoops the common data bus (CDB) for pending operands.
- Each cycle, dispatches at most one ready instruction through registered outputs that drive the ALU's op/rs/rt/pc/imm inputs.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16).
- ROB_WIDTH, 4, width of ROB tag identifying a producer/destination.
- OP_WIDTH, 6, width of decoded op code (matches OP_TYPE).
- XLEN, 32, data width (matches REG_TYPE).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global ready; when low the block freezes.
- flush_in  in  1  misprediction flush; clears every entry.
- issue_valid_in  in  1  new instruction present this cycle.
- issue_op_in  in  OP_WIDTH  decoded op.
- issue_vj_in  in  XLEN  rs value (valid when issue_qj_busy_in=0).
- issue_qj_busy_in  in  1  rs still pending.
- issue_qj_in  in  ROB_WIDTH  rs producer tag.
- issue_vk_in  in  XLEN  rt value.
- issue_qk_busy_in  in  1  rt still pending.
- issue_qk_in  in  ROB_WIDTH  rt producer tag.
- issue_pc_in  in  XLEN  instruction pc.
- issue_imm_in  in  XLEN  immediate.
- issue_dest_in  in  ROB_WIDTH  destination ROB tag.
- full_out  out  1  no free entry (combinational from state).
- cdb_valid_in  in  1  broadcast valid.
- cdb_tag_in  in  ROB_WIDTH  broadcast producer tag.
- cdb_value_in  in  XLEN  broadcast value.
- exec_valid_out  out  1  dispatch valid to ALU.
- exec_op_out  out  OP_WIDTH  to ALU op.
- exec_rs_out  out  XLEN  to ALU rs.
- exec_rt_out  out  XLEN  to ALU rt.
- exec_pc_out  out  XLEN  to ALU pc.
- exec_imm_out  out  XLEN  to ALU imm.
- exec_dest_out  out  ROB_WIDTH  ROB tag of dispatched instruction.

Behaviour:
- Clock and reset: one clock, clk_in, rising edge. rst_in is synchronous and active-high. Reset clears all busy bits. All exec_* outputs reset to 0. full_out is 0 after reset.
- Priority at each edge: rst_in > flush_in > !rdy_in (hold everything, outputs keep value) > normal operation.
- Flush: all entries freed; exec_valid_out=0 next cycle. Issue and CDB in the same cycle are ignored.
- Entry state: busy, op, vj, qj_busy, qj, vk, qk_busy, qk, pc, imm, dest. An entry is ready when busy and !qj_busy and !qk_busy.
- Issue:
  - If issue_valid_in and !full_out, write the lowest-index free entry.
  - An operand is stored ready if its busy flag is 0, or if cdb_valid_in is high and cdb_tag_in equals its tag in that same cycle. In the CDB case, store cdb_value_in (same-cycle bypass).
  - Issue while full_out=1 is ignored; the upstream stage must not do it.
- Wakeup: each edge, every busy entry with a pending operand whose tag equals cdb_tag_in (cdb_valid_in=1) captures cdb_value_in and clears that busy flag. Both operands may wake in one cycle.
- Select/dispatch:
  - Each edge, pick the lowest-index ready entry, based on state before the edge.
  - Register its fields to exec_*, set exec_valid_out=1, and free the entry.
  - If no entry is ready, exec_valid_out=0 and the other exec_* outputs hold.
  - exec_valid_out is a one-cycle pulse per dispatch. The ALU has no backpressure.
- Latency:
  - An instruction issued ready at edge E dispatches at edge E+1 at the earliest.
  - An entry woken at edge E dispatches at E+1 at the earliest.
  - A wakeup never dispatches in the same edge it occurs.
- full_out = all entries busy (current state). It does not account for a same-cycle dispatch; this is conservative.
- A dispatching entry and an issue never target the same slot in one cycle, because issue uses only currently free entries.

Test Plan:
- Reset, then issue ADDI with qj_busy=0, vj=5, imm=7, dest=3. Required: exec_valid_out=1 exactly one cycle later with op=ADDI, rs=5, imm=7, dest=3, then 0.
- Issue ADD with qj_busy=1, qj=2, vk=10. Hold 3 cycles (exec_valid_out stays 0). Then CDB tag=2, value=20. Required: dispatch on the following edge with rs=20, rt=10.
- Issue with qj=6 while CDB tag=6, value=0xDEAD in the same cycle. Required: stored ready, dispatch next edge with rs=0xDEAD.
- Fill all 8 entries with pending operands. Required: full_out=1 and a 9th issue is ignored. Then broadcast tags waking entries 5 and 1 together. Required: entry 1 dispatches first, entry 5 on the next edge, and full_out falls after the first dispatch.
- With 4 busy entries, pulse flush_in. Required: full_out=0 and exec_valid_out=0 next cycle, and a later CDB matching old tags causes no dispatch.
- Hold rdy_in=0 with a ready entry and CDB activity. Required: no dispatch or wakeup and outputs hold. When rdy_in=1 resumes, dispatch occurs on the next edge.
